// File: rtl/multiword_add_sequencer_pkg.sv
// multiword_add_sequencer_pkg
//   Shared definitions for the multiword add sequencer: default operand and
//   slice widths, plus the sequencer FSM state encoding.
package multiword_add_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 24;
  localparam int DEFAULT_SLICE = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_sequencer_adder_slice.sv
// adder_slice
//   Purely combinational SLICE-bit ripple-carry adder. The sequencer time-
//   multiplexes this single slice across all words of the operands.
//   Ports:
//     a, b  [SLICE-1:0]  slice operands
//     cin                carry into slice bit 0
//     sum   [SLICE-1:0]  slice sum
//     cout               carry out of slice bit SLICE-1
module adder_slice #(
  parameter int SLICE = 6
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  // Bit-serial carry chain written as a loop so it stays a true ripple adder.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Adds two WIDTH-bit operands plus a carry-in using one shared SLICE-bit
//   adder, one slice per cycle, LSB slice first. Valid/ready handshakes on
//   both the operand and the result side.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     in_valid/in_ready   operand handshake (ready only in IDLE)
//     a, b, cin           operands and carry into bit 0
//     out_valid/out_ready result handshake (valid only in DONE)
//     sum, cout           (a + b + cin) mod 2^WIDTH and carry out of the MSB
//     busy                high while slices are being added
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_params
      $error("multiword_add_sequencer: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg, cout_reg;
  logic [IDXW-1:0]   idx_reg;

  logic [SLICE-1:0]  slice_a, slice_b, slice_sum;
  logic              slice_cout;
  logic              last_slice;

  assign slice_a    = a_reg[idx_reg*SLICE +: SLICE];
  assign slice_b    = b_reg[idx_reg*SLICE +: SLICE];
  assign last_slice = (idx_reg == IDXW'(NSLICE - 1));

  adder_slice #(.SLICE(SLICE)) u_adder_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid)   state_next = ST_RUN;
      ST_RUN:  if (last_slice) state_next = ST_DONE;
      ST_DONE: if (out_ready)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
          end
        end
        ST_RUN: begin
          sum_reg[idx_reg*SLICE +: SLICE] <= slice_sum;
          carry_reg                       <= slice_cout;
          // The MSB carry is parked in cout and never recirculated to slice 0.
          if (last_slice) cout_reg <= slice_cout;
          else            idx_reg  <= idx_reg + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_RUN);
  assign out_valid = (state_reg == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer
//   Randomised self-checking bench: each result is compared with a+b+cin
//   computed directly in wide integer arithmetic.
module tb_multiword_add_sequencer;

  localparam int WIDTH  = 24;
  localparam int SLICE  = 6;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'($urandom_range(0, 1));
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    cin      = 1'($urandom_range(0, 1));
  endtask

  // One complete transaction. hold = cycles of out_ready=0 in DONE, or
  // random out_ready when rand_ready is set.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tcin, input int hold, input bit rand_ready);
    logic [WIDTH:0] ref_full;
    logic [WIDTH-1:0] exp_sum;
    logic exp_cout;
    int n;
    bit accepted;
    ref_full = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tcin};
    exp_sum  = ref_full[WIDTH-1:0];
    exp_cout = ref_full[WIDTH];

    a = ta; b = tb; cin = tcin; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("hs_ready", {31'd0, in_ready}, 32'd1);
    if (!in_ready) begin in_valid = 1'b0; return; end
    tick();                         // handshake edge
    scramble_inputs();              // must not affect the running add
    check("busy_run", {31'd0, busy}, 32'd1);

    n = 0;
    while (!out_valid && n < 50) begin
      tick(); n++;
      scramble_inputs();
    end
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("latency", 32'(n + 1), 32'(NSLICE + 1));
    check("sum", {8'd0, sum}, {8'd0, exp_sum});
    check("cout", {31'd0, cout}, {31'd0, exp_cout});
    check("in_ready_done", {31'd0, in_ready}, 32'd0);

    for (int k = 0; k < 300; k++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) == 0) || (k > 20);
      else            out_ready = (k >= hold);
      scramble_inputs();
      accepted = out_ready;
      tick();
      if (accepted) begin
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        break;
      end else begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_sum", {8'd0, sum}, {8'd0, exp_sum});
        check("hold_cout", {31'd0, cout}, {31'd0, exp_cout});
      end
    end
    txn_id++;
    $display("txn %0d a=%h b=%h cin=%0d sum=%h cout=%0d exp=%h/%0d",
             txn_id, ta, tb, tcin, sum, cout, exp_sum, exp_cout);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {8'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);

    run_txn(24'h000000, 24'h000000, 1'b0, 0, 1'b0);
    run_txn(24'hFFFFFF, 24'h000000, 1'b1, 0, 1'b0);
    run_txn(24'h03F03F, 24'h000001, 1'b0, 0, 1'b0);
    run_txn(24'hFFFFFF, 24'hFFFFFF, 1'b1, 0, 1'b0);
    run_txn(24'h123456, 24'h654321, 1'b0, 10, 1'b0);

    // Reset abandoned mid-operation, while slice 2 is being added.
    a = 24'hABCDEF; b = 24'h111111; cin = 1'b1; in_valid = 1'b1;
    tick();                          // handshake edge (IDLE)
    in_valid = 1'b0;
    tick(); tick();                  // slices 0 and 1 done
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_sum", {8'd0, sum}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abandoned_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_txn(24'hABCDEF, 24'h111111, 1'b1, 0, 1'b0);

    for (int t = 0; t < 1000; t++) begin
      run_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
